// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

   // Default word width shared by uart_rx, uart_tx and uart_tx_fifo
   localparam int DATA_BITS_DEF = 8;

   // Parity selection used by uart_rx/uart_tx
   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_e;

   // Handoff state of the transmit FIFO towards uart_tx
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_BUSY    = 2'd2
   } txf_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - dual-port register array, synchronous write, combinational read
module sync_fifo_mem #(
   parameter  int DATA_BITS = 8,
   parameter  int DEPTH     = 16,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [DATA_BITS-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic [DATA_BITS-1:0] rdata
);

   logic [DATA_BITS-1:0] mem [DEPTH];

   // Write port: one word per enabled edge, no reset so a block RAM can drop in
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit FIFO feeding uart_tx over a level valid/ready handoff
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int DATA_BITS = DATA_BITS_DEF,
   parameter  int DEPTH     = 16,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 wr_ready,
   input  logic                 flush,
   output logic                 tx_valid,
   output logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_ready,
   output logic [CW-1:0]        count,
   output logic                 overflow
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CW-1:0]        count_q;
   logic                 overflow_q;
   logic                 tx_valid_q;
   logic [DATA_BITS-1:0] tx_data_q;
   logic [DATA_BITS-1:0] rd_word;
   txf_state_e           state_q;
   txf_state_e           state_d;
   logic                 full;
   logic                 empty;
   logic                 wr_en;
   logic                 pop;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign wr_ready = !full;

   // A flush discards the same-cycle write without flagging overflow
   assign wr_en = wr_valid && !full && !flush;

   sync_fifo_mem #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   // Handoff next state: pop only from IDLE, so BUSY->IDLE always costs one idle cycle.
   // A pop is suppressed on a flush edge so discarded contents never reach the line.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty && tx_ready && !flush) begin
               pop     = 1'b1;
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (!tx_ready) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (tx_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Handoff state register; flush deliberately leaves an in-flight word alone
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output word register: captured on pop, held through PRESENT and BUSY
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         tx_valid_q <= (state_d == ST_PRESENT);
         if (pop) begin
            tx_data_q <= rd_word;
         end
      end
   end

   // Circular pointers, wrapping naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   // Stored-word count, excluding the word handed to uart_tx
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count_q <= '0;
      end else begin
         unique case ({wr_en, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky overflow: any write attempt while full, cleared only by rst or flush
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         overflow_q <= 1'b0;
      end else if (wr_valid && full) begin
         overflow_q <= 1'b1;
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a uart_tx stand-in sink
module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data  = '0;
   logic          flush    = 1'b0;
   logic          tx_ready = 1'b1;
   logic          wr_ready;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic [CW-1:0] count;
   logic          overflow;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] sb[$];
   bit            m_ovf      = 1'b0;
   bit            m_inflight = 1'b0;
   bit            m_pres     = 1'b0;

   // sink (uart_tx stand-in)
   bit            sink_auto  = 1'b0;
   bit            frame_rand = 1'b0;
   int            frame_len  = 100;
   int            sink_busy  = 0;
   logic [DW-1:0] sent[$];

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .flush    (flush),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .count    (count),
      .overflow (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [DW-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (sent.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(name, sent.size() >= n, 1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k;
      k = 0;
      while (!(mq.size() == 0 && !m_inflight && sink_busy == 0 && tx_ready) && k < budget) begin
         tick();
         k++;
      end
      check(name, (mq.size() == 0 && !m_inflight && sink_busy == 0), 1);
   endtask

   // Reference model: FIFO as a queue, one word in flight to the line at a time
   initial begin
      int sz;
      forever begin
         @(posedge clk);
         sz = mq.size();
         if (rst) begin
            mq.delete();
            sb.delete();
            m_ovf      = 1'b0;
            m_inflight = 1'b0;
            m_pres     = 1'b0;
         end else begin
            if (!m_inflight) begin
               if (!flush && tx_ready && sz > 0) begin
                  sb.push_back(mq.pop_front());
                  m_inflight = 1'b1;
                  m_pres     = 1'b1;
               end
            end else if (m_pres) begin
               if (!tx_ready) m_pres = 1'b0;
            end else if (tx_ready) begin
               m_inflight = 1'b0;
            end
            if (flush) begin
               mq.delete();
               m_ovf = 1'b0;
            end else if (wr_valid) begin
               if (sz < DEPTH) mq.push_back(wr_data);
               else            m_ovf = 1'b1;
            end
         end
      end
   end

   // Monitor: compares DUT outputs with the model every cycle, tx words against the scoreboard
   initial begin
      logic          prev_valid;
      logic [DW-1:0] last_exp;
      prev_valid = 1'b0;
      last_exp   = '0;
      forever begin
         @(negedge clk);
         check("count", count, mq.size());
         check("wr_ready", wr_ready, mq.size() < DEPTH);
         check("overflow", overflow, m_ovf);
         check("tx_valid", tx_valid, m_pres);
         if (tx_valid === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
               check("tx_unexpected", tx_data, 32'hFFFF_FFFF);
            end else begin
               last_exp = sb.pop_front();
               check("tx_data", tx_data, last_exp);
            end
         end else if (tx_valid === 1'b1) begin
            check("tx_data_hold", tx_data, last_exp);
         end
         prev_valid = (tx_valid === 1'b1);
      end
   end

   // Sink: accepts a presented word when idle, then stays busy for a frame time
   initial begin
      logic          sv;
      logic [DW-1:0] sd;
      forever begin
         @(negedge clk);
         sv = tx_valid;
         sd = tx_data;
         @(posedge clk);
         #1;
         if (sink_auto) begin
            if (sink_busy > 0) begin
               sink_busy--;
               if (sink_busy == 0) tx_ready = 1'b1;
            end else if (sv === 1'b1 && tx_ready) begin
               sent.push_back(sd);
               tx_ready  = 1'b0;
               sink_busy = frame_rand ? int'($urandom_range(1, 30)) : frame_len;
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout required completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      // reset state
      tick();
      tick();
      check("rst_wr_ready", wr_ready, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 0);
      rst = 1'b0;
      tick();

      // single byte
      put(8'hA5);
      check("single_count1", count, 1);
      check("single_valid0", tx_valid, 0);
      tick();
      check("single_valid1", tx_valid, 1);
      check("single_data", tx_data, 8'hA5);
      check("single_count0", count, 0);
      tx_ready = 1'b0;
      tick();
      check("single_busy_valid", tx_valid, 0);
      repeat (9) tick();
      check("single_busy_hold", tx_valid, 0);
      tx_ready = 1'b1;
      tick();
      tick();
      check("single_idle_valid", tx_valid, 0);

      // fill and overflow
      tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) put(8'(i));
      check("fill_count", count, 16);
      check("fill_wr_ready", wr_ready, 0);
      put(8'hFF);
      check("fill_overflow", overflow, 1);
      check("fill_count_after", count, 16);

      // drain in order, frame time 10 bits x divide-by-10
      sent.delete();
      frame_len = 100;
      tx_ready  = 1'b1;
      sink_auto = 1'b1;
      wait_sent(16, 16 * 110 + 50, "drain_timeout");
      for (int i = 0; i < 16; i++) begin
         if (i < sent.size()) check("drain_order", sent[i], i);
      end
      for (int i = 0; i < 20; i++) begin
         int k;
         k = 0;
         while (!wr_ready && k < 2000) begin
            tick();
            k++;
         end
         put(8'(8'h40 + i));
      end
      wait_sent(36, 20 * 110 + 50, "wrap_timeout");
      for (int i = 0; i < 20; i++) begin
         if (16 + i < sent.size()) check("wrap_order", sent[16+i], 8'h40 + i);
      end
      wait_idle(500, "wrap_idle");
      check("wrap_count", count, 0);
      sink_auto = 1'b0;

      // simultaneous write and pop
      tx_ready = 1'b0;
      put(8'h11);
      put(8'h22);
      put(8'h33);
      check("simul_pre_count", count, 3);
      tx_ready = 1'b1;
      put(8'h3C);
      check("simul_count", count, 3);
      check("simul_valid", tx_valid, 1);
      check("simul_data", tx_data, 8'h11);
      sent.delete();
      frame_len = 5;
      sink_auto = 1'b1;
      wait_sent(4, 200, "simul_timeout");
      if (sent.size() >= 4) begin
         check("simul_o0", sent[0], 8'h11);
         check("simul_o1", sent[1], 8'h22);
         check("simul_o2", sent[2], 8'h33);
         check("simul_tail", sent[3], 8'h3C);
      end
      wait_idle(200, "simul_idle");
      sink_auto = 1'b0;

      // flush mid-frame
      tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) put(8'(8'h60 + i));
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      tick();
      check("flush_pre_count", count, 5);
      check("flush_pre_ovf", overflow, 1);
      check("flush_pre_busy", tx_valid, 0);
      flush    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      tick();
      flush    = 1'b0;
      wr_valid = 1'b0;
      check("flush_count", count, 0);
      check("flush_ovf", overflow, 0);
      repeat (3) tick();
      tx_ready = 1'b1;
      tick();
      tick();
      check("flush_discard_valid", tx_valid, 0);
      check("flush_discard_count", count, 0);
      put(8'h12);
      tick();
      check("flush_next_valid", tx_valid, 1);
      check("flush_next_data", tx_data, 8'h12);
      tx_ready = 1'b0;
      tick();
      tx_ready = 1'b1;
      tick();
      tick();

      // reset while presenting
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) put(8'(8'h80 + i));
      tx_ready = 1'b1;
      tick();
      check("rstmid_pre_valid", tx_valid, 1);
      check("rstmid_pre_count", count, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_valid", tx_valid, 0);
      check("rstmid_count", count, 0);
      check("rstmid_wr_ready", wr_ready, 1);
      put(8'h5A);
      tick();
      check("rstmid_next_valid", tx_valid, 1);
      check("rstmid_next_data", tx_data, 8'h5A);
      tx_ready = 1'b0;
      tick();
      tx_ready = 1'b1;
      tick();
      tick();

      // randomized traffic against the model
      frame_rand = 1'b1;
      sink_auto  = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         rst      = ($urandom_range(0, 999) < 3);
         flush    = ($urandom_range(0, 99) < 2);
         wr_valid = ($urandom_range(0, 99) < 55);
         wr_data  = 8'($urandom);
         tick();
      end
      rst      = 1'b0;
      flush    = 1'b0;
      wr_valid = 1'b0;
      wait_idle(3000, "random_drain");
      check("random_final_count", count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer directly upstream of uart_tx.
- Accepts bytes from user logic on a valid/ready write port and stores them in a circular FIFO.
- Hands bytes one at a time to uart_tx over its level-style valid/ready interface.
- Decouples bursty producers from the serial line rate; reports fill level and a sticky overflow flag.

Parameters:
- DATA_BITS, 8, width of each stored word; must equal uart_tx DATA_BITS.
- DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  producer has a word on wr_data.
- wr_data  in  DATA_BITS  word to enqueue.
- wr_ready  out  1  FIFO not full; write accepted when wr_valid & wr_ready at a clk edge.
- flush  in  1  synchronous clear of stored contents.
- tx_valid  out  1  drives uart_tx valid.
- tx_data  out  DATA_BITS  drives uart_tx data_in.
- tx_ready  in  1  from uart_tx ready; high = idle, low = frame in progress.
- count  out  $clog2(DEPTH+1)  number of stored words, excluding the word in flight.
- overflow  out  1  sticky; set by a write attempt while full.

Behaviour:
- Reset (rst high at an edge):
  - wr_ready=1, tx_valid=0, tx_data=0, count=0, overflow=0.
  - Pointers are 0 and the FSM returns to IDLE.
  - Reset mid-frame abandons the handoff; the next presentation waits for tx_ready=1 as usual.
- Storage:
  - Memory is DEPTH x DATA_BITS. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - full = (count == DEPTH); empty = (count == 0); wr_ready = !full, combinational from registered count.
- Write:
  - wr_valid & !full: store at wr_ptr, wr_ptr+1, count+1.
  - wr_valid & full: word dropped, overflow<=1. overflow stays set until rst or flush.
- Handoff FSM (states IDLE, PRESENT, BUSY):
  - IDLE: if !empty & tx_ready, then tx_data<=mem[rd_ptr], rd_ptr+1, count-1, tx_valid<=1, go to PRESENT.
  - PRESENT: tx_valid and tx_data held stable. When tx_ready==0 (uart_tx accepted), tx_valid<=0 and go to BUSY.
  - BUSY: tx_data held. When tx_ready==1 (frame complete), go to IDLE.
  - Back-to-back: the next pop may occur on the same edge that leaves BUSY is not allowed; the pop occurs in IDLE one cycle later. This leaves a minimum one-cycle gap.
- Latency: a write accepted at edge N on an empty FIFO with tx_ready=1 gives count=1 after N and tx_valid=1 after N+1.
- Simultaneous write and pop in the same cycle: count unchanged, both pointers advance.
  - When full, wr_ready is 0, so a write coinciding with a pop is still rejected and overflow is set.
- flush:
  - Sets wr_ptr=rd_ptr=0, count=0, overflow=0.
  - Does not affect the FSM: a word already in PRESENT/BUSY completes normally.
  - flush has priority over a same-cycle write; that write is discarded and does not set overflow.
  - flush and rst are both sampled only at clk edges.
- Stall: if tx_ready stays high in PRESENT, tx_valid remains asserted indefinitely. There is no timeout.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (IDLE/PRESENT/BUSY);
  - the parity-type constants (NONE=0, EVEN=1, ODD=2) already used by uart_rx/uart_tx, for later reuse;
  - the DATA_BITS default.
- One natural sub-module: sync_fifo_mem. It is a simple dual-port register array with write enable and combinational read, so a block RAM can later replace it.
- Pointer, count and FSM logic stay in uart_tx_fifo.

Test Plan:
- Single byte:
  - Stimulus: after reset, write 0xA5 with tx_ready=1.
  - Required: count=1 after one edge; next edge tx_valid=1, tx_data=0xA5, count=0.
  - Then drop tx_ready for 10 cycles: tx_valid=0 on the first low cycle, FSM in BUSY; tx_ready high returns it to IDLE.
- Fill and overflow:
  - Stimulus: with tx_ready held 0 (uart_tx busy), write 0x00..0x0F (16 words), then write 0xFF.
  - Required: count=16, wr_ready=0 after the 16th write, 0xFF dropped, overflow=1.
- Drain order and wrap:
  - Stimulus: continue from the full FIFO and connect a real uart_tx with BAUD_DIV=10.
  - Required: serial frames carry 0x00..0x0F in order. Then 20 more writes wrap the pointers and also emerge in order, and count returns to 0.
- Simultaneous write and pop:
  - Stimulus: count=3 and IDLE with tx_ready=1, while writing 0x3C.
  - Required: count stays 3, tx_data = oldest word, and 0x3C lands at the tail.
- flush mid-frame:
  - Stimulus: in BUSY with count=5 and overflow=1, pulse flush together with wr_valid and 0x77.
  - Required: count=0, overflow=0, 0x77 discarded, and the in-flight byte completes on tx.
- Reset mid-operation:
  - Stimulus: assert rst in PRESENT with count=4.
  - Required: next edge tx_valid=0, count=0, wr_ready=1, and a subsequent write of 0x5A is transmitted normally.
